// File: rtl/alu_decode_q_if.sv
// Handshake bundle for alu_decode_q: instruction stream in, decoded stream out.
// master = producer/consumer side, slave = the decode queue.
interface alu_decode_q_if #(
   parameter int CTRL_W = 8,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [PC_W-1:0]   out_pc;
   logic [CTRL_W-1:0] out_alucontrol;
   logic [2:0]        out_cls;
   logic              out_ri;
   logic [CW-1:0]     count;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_alucontrol, out_cls, out_ri, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_alucontrol, out_cls, out_ri, count
   );
endinterface

// File: rtl/alu_decode_q.sv
// Queued MIPS ALU decoder: combinational decode into a DEPTH-entry FIFO with PC.
// Define ALU_DECODE_Q_RI_EN to store and drive the reserved-instruction flag.
module alu_decode_q #(
   parameter int CTRL_W = 8,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   alu_decode_q_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [2:0] CLS_NONE = 3'd0, CLS_ALU = 3'd1, CLS_HILO = 3'd2, CLS_BR = 3'd3,
                          CLS_LD = 3'd4, CLS_ST = 3'd5, CLS_PRIV = 3'd6, CLS_TRAP = 3'd7;

   localparam logic [7:0]
      EXE_AND_OP  = 8'h24, EXE_OR_OP    = 8'h25, EXE_XOR_OP   = 8'h26, EXE_NOR_OP  = 8'h27,
      EXE_ANDI_OP = 8'h59, EXE_ORI_OP   = 8'h5A, EXE_XORI_OP  = 8'h5B, EXE_LUI_OP  = 8'h5C,
      EXE_SLL_OP  = 8'h7C, EXE_SLLV_OP  = 8'h04, EXE_SRL_OP   = 8'h02, EXE_SRLV_OP = 8'h06,
      EXE_SRA_OP  = 8'h03, EXE_SRAV_OP  = 8'h07,
      EXE_MFHI_OP = 8'h10, EXE_MTHI_OP  = 8'h11, EXE_MFLO_OP  = 8'h12, EXE_MTLO_OP = 8'h13,
      EXE_SLT_OP  = 8'h2A, EXE_SLTU_OP  = 8'h2B, EXE_SLTI_OP  = 8'h57, EXE_SLTIU_OP = 8'h58,
      EXE_ADD_OP  = 8'h20, EXE_ADDU_OP  = 8'h21, EXE_SUB_OP   = 8'h22, EXE_SUBU_OP = 8'h23,
      EXE_ADDI_OP = 8'h55, EXE_ADDIU_OP = 8'h56,
      EXE_MULT_OP = 8'h18, EXE_MULTU_OP = 8'h19, EXE_DIV_OP   = 8'h1A, EXE_DIVU_OP = 8'h1B,
      EXE_J_OP    = 8'h4F, EXE_JAL_OP   = 8'h50, EXE_JALR_OP  = 8'h09, EXE_JR_OP   = 8'h08,
      EXE_BEQ_OP  = 8'h51, EXE_BNE_OP   = 8'h52, EXE_BLEZ_OP  = 8'h53, EXE_BGTZ_OP = 8'h54,
      EXE_BLTZ_OP = 8'h40, EXE_BGEZ_OP  = 8'h41, EXE_BLTZAL_OP = 8'h4A, EXE_BGEZAL_OP = 8'h4B,
      EXE_LB_OP   = 8'hE0, EXE_LH_OP    = 8'hE1, EXE_LW_OP    = 8'hE3, EXE_LBU_OP  = 8'hE4,
      EXE_LHU_OP  = 8'hE5, EXE_SB_OP    = 8'hE8, EXE_SH_OP    = 8'hE9, EXE_SW_OP   = 8'hEB,
      EXE_SYSCALL_OP = 8'h0C, EXE_BREAK_OP = 8'h0D,
      EXE_ERET_OP = 8'h6B, EXE_MTC0_OP  = 8'h5D, EXE_MFC0_OP  = 8'h5E;

   logic [5:0] op, funct;
   logic [4:0] rs, rt;
   logic [7:0] dec_ctrl;
   logic [2:0] dec_cls;

   assign op    = bus.in_instr[31:26];
   assign rs    = bus.in_instr[25:21];
   assign rt    = bus.in_instr[20:16];
   assign funct = bus.in_instr[5:0];

   // Every recognised instruction has a non-zero class, so cls == 0 doubles as "unmatched".
   always_comb begin
      dec_ctrl = '0;
      dec_cls  = CLS_NONE;
      case (op)
         6'h00: case (funct)
            6'h00: {dec_ctrl, dec_cls} = {EXE_SLL_OP,  CLS_ALU};
            6'h02: {dec_ctrl, dec_cls} = {EXE_SRL_OP,  CLS_ALU};
            6'h03: {dec_ctrl, dec_cls} = {EXE_SRA_OP,  CLS_ALU};
            6'h04: {dec_ctrl, dec_cls} = {EXE_SLLV_OP, CLS_ALU};
            6'h06: {dec_ctrl, dec_cls} = {EXE_SRLV_OP, CLS_ALU};
            6'h07: {dec_ctrl, dec_cls} = {EXE_SRAV_OP, CLS_ALU};
            6'h08: {dec_ctrl, dec_cls} = {EXE_JR_OP,   CLS_BR};
            6'h09: {dec_ctrl, dec_cls} = {EXE_JALR_OP, CLS_BR};
            6'h0C: {dec_ctrl, dec_cls} = {EXE_SYSCALL_OP, CLS_TRAP};
            6'h0D: {dec_ctrl, dec_cls} = {EXE_BREAK_OP,   CLS_TRAP};
            6'h10: {dec_ctrl, dec_cls} = {EXE_MFHI_OP, CLS_HILO};
            6'h11: {dec_ctrl, dec_cls} = {EXE_MTHI_OP, CLS_HILO};
            6'h12: {dec_ctrl, dec_cls} = {EXE_MFLO_OP, CLS_HILO};
            6'h13: {dec_ctrl, dec_cls} = {EXE_MTLO_OP, CLS_HILO};
            6'h18: {dec_ctrl, dec_cls} = {EXE_MULT_OP, CLS_HILO};
            6'h19: {dec_ctrl, dec_cls} = {EXE_MULTU_OP, CLS_HILO};
            6'h1A: {dec_ctrl, dec_cls} = {EXE_DIV_OP,  CLS_HILO};
            6'h1B: {dec_ctrl, dec_cls} = {EXE_DIVU_OP, CLS_HILO};
            6'h20: {dec_ctrl, dec_cls} = {EXE_ADD_OP,  CLS_ALU};
            6'h21: {dec_ctrl, dec_cls} = {EXE_ADDU_OP, CLS_ALU};
            6'h22: {dec_ctrl, dec_cls} = {EXE_SUB_OP,  CLS_ALU};
            6'h23: {dec_ctrl, dec_cls} = {EXE_SUBU_OP, CLS_ALU};
            6'h24: {dec_ctrl, dec_cls} = {EXE_AND_OP,  CLS_ALU};
            6'h25: {dec_ctrl, dec_cls} = {EXE_OR_OP,   CLS_ALU};
            6'h26: {dec_ctrl, dec_cls} = {EXE_XOR_OP,  CLS_ALU};
            6'h27: {dec_ctrl, dec_cls} = {EXE_NOR_OP,  CLS_ALU};
            6'h2A: {dec_ctrl, dec_cls} = {EXE_SLT_OP,  CLS_ALU};
            6'h2B: {dec_ctrl, dec_cls} = {EXE_SLTU_OP, CLS_ALU};
            default: ;
         endcase
         6'h01: case (rt)
            5'h00: {dec_ctrl, dec_cls} = {EXE_BLTZ_OP,   CLS_BR};
            5'h01: {dec_ctrl, dec_cls} = {EXE_BGEZ_OP,   CLS_BR};
            5'h10: {dec_ctrl, dec_cls} = {EXE_BLTZAL_OP, CLS_BR};
            5'h11: {dec_ctrl, dec_cls} = {EXE_BGEZAL_OP, CLS_BR};
            default: ;
         endcase
         6'h02: {dec_ctrl, dec_cls} = {EXE_J_OP,    CLS_BR};
         6'h03: {dec_ctrl, dec_cls} = {EXE_JAL_OP,  CLS_BR};
         6'h04: {dec_ctrl, dec_cls} = {EXE_BEQ_OP,  CLS_BR};
         6'h05: {dec_ctrl, dec_cls} = {EXE_BNE_OP,  CLS_BR};
         6'h06: {dec_ctrl, dec_cls} = {EXE_BLEZ_OP, CLS_BR};
         6'h07: {dec_ctrl, dec_cls} = {EXE_BGTZ_OP, CLS_BR};
         6'h08: {dec_ctrl, dec_cls} = {EXE_ADDI_OP,  CLS_ALU};
         6'h09: {dec_ctrl, dec_cls} = {EXE_ADDIU_OP, CLS_ALU};
         6'h0A: {dec_ctrl, dec_cls} = {EXE_SLTI_OP,  CLS_ALU};
         6'h0B: {dec_ctrl, dec_cls} = {EXE_SLTIU_OP, CLS_ALU};
         6'h0C: {dec_ctrl, dec_cls} = {EXE_ANDI_OP,  CLS_ALU};
         6'h0D: {dec_ctrl, dec_cls} = {EXE_ORI_OP,   CLS_ALU};
         6'h0E: {dec_ctrl, dec_cls} = {EXE_XORI_OP,  CLS_ALU};
         6'h0F: {dec_ctrl, dec_cls} = {EXE_LUI_OP,   CLS_ALU};
         6'h10: begin
            if (bus.in_instr == 32'h4200_0018) {dec_ctrl, dec_cls} = {EXE_ERET_OP, CLS_PRIV};
            else if (rs == 5'b00100)           {dec_ctrl, dec_cls} = {EXE_MTC0_OP, CLS_PRIV};
            else if (rs == 5'b00000)           {dec_ctrl, dec_cls} = {EXE_MFC0_OP, CLS_PRIV};
         end
         6'h20: {dec_ctrl, dec_cls} = {EXE_LB_OP,  CLS_LD};
         6'h21: {dec_ctrl, dec_cls} = {EXE_LH_OP,  CLS_LD};
         6'h23: {dec_ctrl, dec_cls} = {EXE_LW_OP,  CLS_LD};
         6'h24: {dec_ctrl, dec_cls} = {EXE_LBU_OP, CLS_LD};
         6'h25: {dec_ctrl, dec_cls} = {EXE_LHU_OP, CLS_LD};
         6'h28: {dec_ctrl, dec_cls} = {EXE_SB_OP,  CLS_ST};
         6'h29: {dec_ctrl, dec_cls} = {EXE_SH_OP,  CLS_ST};
         6'h2B: {dec_ctrl, dec_cls} = {EXE_SW_OP,  CLS_ST};
         default: ;
      endcase
   end

   logic [31:0]     mem_instr [DEPTH];
   logic [PC_W-1:0] mem_pc    [DEPTH];
   logic [7:0]      mem_ctrl  [DEPTH];
   logic [2:0]      mem_cls   [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            in_ready, out_valid, push, pop;

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = bus.in_valid & in_ready & ~flush;
   assign pop       = out_valid & bus.out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr] <= bus.in_instr;
            mem_pc[wr_ptr]    <= bus.in_pc;
            mem_ctrl[wr_ptr]  <= dec_ctrl;
            mem_cls[wr_ptr]   <= dec_cls;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef ALU_DECODE_Q_RI_EN
   logic mem_ri [DEPTH];

   always_ff @(posedge clk) begin
      if (push) mem_ri[wr_ptr] <= (dec_cls == CLS_NONE);
   end

   assign bus.out_ri = out_valid ? mem_ri[rd_ptr] : 1'b0;
`else
   assign bus.out_ri = 1'b0;
`endif

   // Data is masked to zero whenever the queue is empty, so stale slots never leak out.
   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid;
   assign bus.count          = count;
   assign bus.out_instr      = out_valid ? mem_instr[rd_ptr] : '0;
   assign bus.out_pc         = out_valid ? mem_pc[rd_ptr] : '0;
   assign bus.out_alucontrol = out_valid ? CTRL_W'(mem_ctrl[rd_ptr]) : '0;
   assign bus.out_cls        = out_valid ? mem_cls[rd_ptr] : 3'd0;
endmodule

// File: tb/tb_alu_decode_q.sv
// Scoreboard bench for alu_decode_q: expected entries queued on push, compared on pop.
module tb_alu_decode_q;
   localparam int DEPTH = 2;
`ifdef ALU_DECODE_Q_RI_EN
   localparam bit RI_EN = 1'b1;
`else
   localparam bit RI_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [7:0]  ctrl;
      logic [2:0]  cls;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [7:0]  ctrl;
      logic [2:0]  cls;
      logic        ri;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;
   exp_t sb[$];
   vec_t tbl[$];
   vec_t cur;
   logic [31:0] pc_next = 32'h0040_0000;

   always #5 clk = ~clk;

   alu_decode_q_if #(.CTRL_W(8), .PC_W(32), .DEPTH(DEPTH)) bus ();
   alu_decode_q #(.CTRL_W(8), .PC_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cur          = v;
      bus.in_valid = 1'b1;
      bus.in_instr = v.instr;
      bus.in_pc    = pc_next;
      pc_next      = pc_next + 32'd4;
   endtask

   // One clock: score pop/push from the pre-edge handshake, then check occupancy after it.
   task automatic step();
      bit   do_push, do_pop;
      exp_t e;
      do_push = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && !flush && !rst;
      do_pop  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1) && !flush && !rst;
      if (do_pop) begin
         if (sb.size() == 0) begin
            check_val("spurious_pop", 32'(bus.out_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("pop_instr", bus.out_instr, e.instr);
            check_val("pop_pc",    bus.out_pc, e.pc);
            check_val("pop_ctrl",  32'(bus.out_alucontrol), 32'(e.ctrl));
            check_val("pop_cls",   32'(bus.out_cls), 32'(e.cls));
            check_val("pop_ri",    32'(bus.out_ri), 32'(e.ri));
         end
      end
      if (do_push) begin
         e.instr = bus.in_instr;
         e.pc    = bus.in_pc;
         e.ctrl  = cur.ctrl;
         e.cls   = cur.cls;
         e.ri    = RI_EN && (cur.cls == 3'd0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (rst || flush) sb.delete();
      check_val("count",     32'(bus.count), 32'(sb.size()));
      check_val("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      check_val("in_ready",  32'(bus.in_ready), 32'(sb.size() != DEPTH));
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.in_instr = 32'hDEAD_BEEF;
   endtask

   localparam vec_t V_ADD    = '{32'h0043_0820, 8'h20, 3'd1};
   localparam vec_t V_ORI    = '{32'h3401_0005, 8'h5A, 3'd1};
   localparam vec_t V_LW     = '{32'h8C22_0000, 8'hE3, 3'd4};
   localparam vec_t V_SW     = '{32'hAC22_0004, 8'hEB, 3'd5};
   localparam vec_t V_BEQ    = '{32'h1000_0003, 8'h51, 3'd3};
   localparam vec_t V_RI_OP  = '{32'hFC00_0000, 8'h00, 3'd0};
   localparam vec_t V_RI_RT  = '{32'h0405_0000, 8'h00, 3'd0};

   initial begin
      bus.in_valid  = 1'b1;
      bus.in_instr  = V_ADD.instr;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b0;
      cur           = V_ADD;

      tbl.push_back('{32'h4200_0018, 8'h6B, 3'd6});
      tbl.push_back('{32'h4080_6000, 8'h5D, 3'd6});
      tbl.push_back('{32'h0411_0004, 8'h4B, 3'd3});
      tbl.push_back('{32'h0000_000C, 8'h0C, 3'd7});
      tbl.push_back('{32'h0000_0000, 8'h7C, 3'd1});
      tbl.push_back('{32'h0043_0018, 8'h18, 3'd2});
      tbl.push_back('{32'h03E0_0008, 8'h08, 3'd3});
      tbl.push_back('{32'h4001_6000, 8'h5E, 3'd6});
      tbl.push_back('{32'h4040_0000, 8'h00, 3'd0});
      tbl.push_back('{32'h3C01_1234, 8'h5C, 3'd1});
      tbl.push_back('{32'h0000_000D, 8'h0D, 3'd7});
      tbl.push_back('{32'hA022_0000, 8'hE8, 3'd5});
      tbl.push_back('{32'h0000_003F, 8'h00, 3'd0});
      tbl.push_back('{32'h0000_0012, 8'h12, 3'd2});
      tbl.push_back('{32'h0810_0000, 8'h4F, 3'd3});

      // Reset with in_valid high: nothing may be captured.
      step();
      step();
      rst = 1'b0;
      idle_in();
      #1;
      check_val("rst_count",  32'(bus.count), 32'd0);
      check_val("rst_ovalid", 32'(bus.out_valid), 32'd0);
      check_val("rst_iready", 32'(bus.in_ready), 32'd1);
      check_val("rst_ctrl",   32'(bus.out_alucontrol), 32'd0);
      check_val("rst_instr",  bus.out_instr, 32'd0);

      // Single decode with consumer stalled.
      drive(V_ADD);
      step();
      idle_in();
      check_val("add_valid", 32'(bus.out_valid), 32'd1);
      check_val("add_ctrl",  32'(bus.out_alucontrol), 32'h20);
      check_val("add_cls",   32'(bus.out_cls), 32'd1);
      check_val("add_ri",    32'(bus.out_ri), 32'd0);
      check_val("add_count", 32'(bus.count), 32'd1);
      step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Fill to full, sw held off, then drain in order.
      drive(V_ORI); step();
      drive(V_LW);  step();
      drive(V_SW);  step();
      check_val("full_iready", 32'(bus.in_ready), 32'd0);
      check_val("full_count",  32'(bus.count), 32'd2);
      check_val("full_head",   bus.out_instr, V_ORI.instr);
      step();
      check_val("hold_head",   bus.out_instr, V_ORI.instr);
      bus.out_ready = 1'b1;
      step();
      step();
      check_val("pushpop_count", 32'(bus.count), 32'd1);
      idle_in();
      step();
      step();

      // Flush at full together with a beq push.
      bus.out_ready = 1'b0;
      drive(V_ORI); step();
      drive(V_LW);  step();
      drive(V_BEQ);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle_in();
      check_val("flush_count",  32'(bus.count), 32'd0);
      check_val("flush_ovalid", 32'(bus.out_valid), 32'd0);
      check_val("flush_instr",  bus.out_instr, 32'd0);
      bus.out_ready = 1'b1;
      step();
      step();

      // Special decodes streamed at full rate.
      foreach (tbl[i]) begin
         drive(tbl[i]);
         step();
      end
      idle_in();
      step();
      step();

      // Reserved instructions, with a simultaneous push/pop at count 1.
      bus.out_ready = 1'b0;
      drive(V_RI_OP);
      step();
      bus.out_ready = 1'b1;
      drive(V_RI_RT);
      step();
      check_val("ri_pushpop_count", 32'(bus.count), 32'd1);
      check_val("ri_rt_ctrl", 32'(bus.out_alucontrol), 32'd0);
      check_val("ri_rt_ri",   32'(bus.out_ri), 32'(RI_EN));
      idle_in();
      step();

      // Random traffic.
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 3) != 0) drive(tbl[$urandom_range(0, tbl.size() - 1)]);
         else idle_in();
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // Reset mid-stream drops everything.
      bus.out_ready = 1'b0;
      drive(V_ORI); step();
      drive(V_LW);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_in();
      check_val("midrst_count", 32'(bus.count), 32'd0);

      drive(V_SW); step();
      idle_in();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) step();
      check_val("drain_left", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
